// File: rtl/sap_prog_loader_pkg.sv
// sap_prog_loader_pkg: SAP opcode/ALU constants, loader state encoding and the default fill byte.
package sap_prog_loader_pkg;
   localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                          OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
                          OP_JZ  = 4'h8, OP_OUT = 4'hB, OP_HLT = 4'hC;
   typedef enum logic [1:0] {ALU_PASS, ALU_ADD, ALU_SUB} alu_op_t;
   typedef enum logic [2:0] {LD_IDLE, LD_LOAD, LD_FILL, LD_CHECK, LD_DONE, LD_ERROR} ld_state_t;
   // unloaded words decode as HLT with operand 0
   localparam logic [7:0] FILL_BYTE_DEF = {OP_HLT, 4'h0};
endpackage

// File: rtl/sap_prog_loader_if.sv
// sap_prog_loader_if: byte stream handshake in, RAM write port out.
interface sap_prog_loader_if #(parameter int ADDR_W = 4, parameter int DATA_W = 8);
   logic              in_valid, in_ready, in_last, mem_we;
   logic [DATA_W-1:0] in_data, mem_wdata;
   logic [ADDR_W-1:0] mem_addr;
   modport master (output in_valid, in_data, in_last, input in_ready, mem_we, mem_addr, mem_wdata);
   modport slave  (input in_valid, in_data, in_last, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/sap_prog_loader.sv
// sap_prog_loader: streams a checksummed program image into SAP RAM, fills unused words,
// and releases the CPU from reset only once the image verifies.
module sap_prog_loader
   import sap_prog_loader_pkg::*;
#(
   parameter int              ADDR_W    = 4,
   parameter int              DATA_W    = 8,
   parameter int              DEPTH     = 2**ADDR_W,
   parameter logic [DATA_W-1:0] FILL_BYTE = FILL_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   sap_prog_loader_if.slave  bus,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   byte_count
);
   ld_state_t         state;
   logic [DATA_W-1:0] sum;
   logic [ADDR_W-1:0] fill_addr;
   logic              full, accept;
   assign full   = byte_count == (ADDR_W+1)'(DEPTH);
   assign accept = bus.in_valid && bus.in_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= LD_IDLE;
         cpu_rst       <= 1'b1;
         bus.in_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         byte_count    <= '0;
         sum           <= '0;
         fill_addr     <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            LD_IDLE, LD_DONE, LD_ERROR: if (start) begin
               state        <= LD_LOAD;
               byte_count   <= '0;
               sum          <= '0;
               done         <= 1'b0;
               err          <= 1'b0;
               cpu_rst      <= 1'b1;
               busy         <= 1'b1;
               bus.in_ready <= 1'b1;
            end
            LD_LOAD: if (accept) begin
               sum <= sum + bus.in_data;
               if (bus.in_last) begin
                  bus.in_ready <= 1'b0;
                  fill_addr    <= byte_count[ADDR_W-1:0];
                  state        <= full ? LD_CHECK : LD_FILL;
               end else if (full) begin
                  bus.in_ready <= 1'b0;
                  busy         <= 1'b0;
                  err          <= 1'b1;
                  state        <= LD_ERROR;
               end else begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= byte_count[ADDR_W-1:0];
                  bus.mem_wdata <= bus.in_data;
                  byte_count    <= byte_count + 1'b1;
               end
            end
            LD_FILL: begin
               bus.mem_we    <= 1'b1;
               bus.mem_addr  <= fill_addr;
               bus.mem_wdata <= FILL_BYTE;
               fill_addr     <= fill_addr + 1'b1;
               if (fill_addr == ADDR_W'(DEPTH-1)) state <= LD_CHECK;
            end
            LD_CHECK: begin
               busy    <= 1'b0;
               done    <= sum == '0;
               err     <= sum != '0;
               cpu_rst <= sum != '0;
               state   <= sum == '0 ? LD_DONE : LD_ERROR;
            end
            default: state <= LD_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sap_prog_loader.sv
// tb_sap_prog_loader: directed image loads with hand-computed checksums, RAM write log and latency checks.
module tb_sap_prog_loader;
   logic       clk = 1'b0, rst, start;
   logic       cpu_rst, busy, done, err;
   logic [4:0] byte_count;
   int         checks = 0, errors = 0, cyc = 0, n_acc = 0, n_wr = 0;
   int         acyc [64];
   int         wcyc [64];
   logic [7:0] ram [16];
   sap_prog_loader_if bus ();
   sap_prog_loader dut (.clk(clk), .rst(rst), .start(start), .bus(bus), .cpu_rst(cpu_rst),
                        .busy(busy), .done(done), .err(err), .byte_count(byte_count));
   always #5 clk = ~clk;
   // RAM model and transfer log, sampled with pre-edge values
   always @(posedge clk) begin
      cyc++;
      if (bus.in_valid && bus.in_ready && n_acc < 64) begin acyc[n_acc] = cyc; n_acc++; end
      if (bus.mem_we && n_wr < 64) begin ram[bus.mem_addr] = bus.mem_wdata; wcyc[n_wr] = cyc; n_wr++; end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_log();
      n_acc = 0;
      n_wr  = 0;
      for (int i = 0; i < 16; i++) ram[i] = 8'h55;
   endtask
   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask
   task automatic send(input logic [7:0] d, input logic l, input int gap);
      int t = 0;
      bus.in_valid = 1'b0;
      repeat (gap) tick();
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      do begin @(posedge clk); t++; end while (!bus.in_ready && t < 50);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (t >= 50) chk("send_timeout", 1, 0);
   endtask
   task automatic load_img(input int n, input logic [7:0] cs, input int maxgap);
      for (int i = 0; i < n; i++) send(8'(i + 1), 1'b0, int'($urandom_range(0, maxgap)));
      send(cs, 1'b1, int'($urandom_range(0, maxgap)));
   endtask
   task automatic wait_end();
      int t = 0;
      while (!(done || err) && t < 60) begin tick(); t++; end
      if (t >= 60) chk("end_timeout", 0, 1);
   endtask
   task automatic chk_full_img(input string tag);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_cpu_rst"}, cpu_rst, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_count"}, byte_count, 16);
      chk({tag, "_nwr"}, n_wr, 16);
      for (int i = 0; i < 16; i++) chk($sformatf("%s_ram%0d", tag, i), ram[i], i + 1);
      for (int i = 0; i < 16; i++) chk($sformatf("%s_lat%0d", tag, i), wcyc[i] - acyc[i], 1);
   endtask
   initial begin
      rst = 1'b1; start = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
      clear_log();
      repeat (3) tick();
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_flags", {busy, done, err}, 0);
      chk("rst_count", byte_count, 0);
      rst = 1'b0;
      tick();
      // full image, 0x01..0x10 sums to 0x88, checksum 0x78
      clear_log();
      do_start();
      chk("t1_ready", bus.in_ready, 1);
      chk("t1_busy", busy, 1);
      load_img(16, 8'h78, 0);
      wait_end();
      chk_full_img("t1");
      // short image: 1E+2F+C0=0x10D, checksum F3
      clear_log();
      do_start();
      send(8'h1E, 1'b0, 0); send(8'h2F, 1'b0, 0); send(8'hC0, 1'b0, 0); send(8'hF3, 1'b1, 0);
      wait_end();
      chk("t2_done", done, 1);
      chk("t2_cpu_rst", cpu_rst, 0);
      chk("t2_count", byte_count, 3);
      chk("t2_nwr", n_wr, 16);
      chk("t2_data", {ram[0], ram[1], ram[2]}, 24'h1E2FC0);
      for (int i = 3; i < 16; i++) chk($sformatf("t2_fill%0d", i), ram[i], 8'hC0);
      chk("t2_fill_span", wcyc[15] - wcyc[3], 12);
      // bad checksum then retry
      clear_log();
      do_start();
      load_img(16, 8'h79, 0);
      wait_end();
      chk("t3_err", err, 1);
      chk("t3_done", done, 0);
      chk("t3_cpu_rst", cpu_rst, 1);
      chk("t3_busy", busy, 0);
      clear_log();
      do_start();
      chk("t3_err_clr", err, 0);
      load_img(16, 8'h78, 0);
      wait_end();
      chk_full_img("t3b");
      // overflow: 17 data bytes, no last
      clear_log();
      do_start();
      for (int i = 0; i < 17; i++) send(8'(i + 1), 1'b0, 0);
      chk("t4_err", err, 1);
      chk("t4_we", bus.mem_we, 0);
      chk("t4_cpu_rst", cpu_rst, 1);
      chk("t4_nacc", n_acc, 17);
      chk("t4_nwr", n_wr, 16);
      chk("t4_count", byte_count, 16);
      chk("t4_ram15", ram[15], 8'h10);
      // handshake: source holds data while idle, random gaps during load
      rst = 1'b1; tick(); rst = 1'b0; tick();
      clear_log();
      bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.in_last = 1'b0;
      repeat (3) tick();
      chk("t5_idle_acc", n_acc, 0);
      do_start();
      load_img(16, 8'h78, 3);
      wait_end();
      chk_full_img("t5");
      chk("t5_nacc", n_acc, 17);
      bus.in_valid = 1'b1;
      repeat (3) tick();
      bus.in_valid = 1'b0;
      chk("t5_done_acc", n_acc, 17);
      // reset in the middle of a load
      clear_log();
      do_start();
      for (int i = 0; i < 5; i++) send(8'(i + 1), 1'b0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_cpu_rst", cpu_rst, 1);
      chk("t6_busy", busy, 0);
      chk("t6_we", bus.mem_we, 0);
      chk("t6_count", byte_count, 0);
      chk("t6_ready", bus.in_ready, 0);
      clear_log();
      do_start();
      load_img(16, 8'h78, 0);
      wait_end();
      chk_full_img("t6");
      // zero data bytes: checksum 00 alone, all 16 words filled
      clear_log();
      do_start();
      send(8'h00, 1'b1, 0);
      wait_end();
      chk("t7_done", done, 1);
      chk("t7_count", byte_count, 0);
      chk("t7_nwr", n_wr, 16);
      chk("t7_ram0", ram[0], 8'hC0);
      chk("t7_ram15", ram[15], 8'hC0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
